// File: rtl/fraction_normalizer.sv
// Post-add normalization stage: re-aligns the raw 27-bit fraction sum so the hidden bit
// lands at bit 25, adjusts the biased exponent and flags zero/overflow. Two-stage pipeline.
module fraction_normalizer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] sum_fraction_in,
    input  logic [7:0]  exponent_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] normalized_fraction_out,
    output logic [7:0]  exponent_out,
    output logic        zero_out,
    output logic        overflow_out
);

    logic        s1_valid_q;
    logic [26:0] s1_sum_q;
    logic [7:0]  s1_exp_q;
    logic        s1_carry_q;
    logic        s1_zero_q;
    logic [4:0]  s1_lzc_q;

    logic        s1_en;
    logic        s2_en;
    logic [4:0]  lzc_d;

    logic [8:0]  exp_inc;
    logic [8:0]  exp_m1;
    logic [4:0]  shift;
    logic [24:0] shifted;
    logic [25:0] frac_d;
    logic [7:0]  exp_d;
    logic        zero_d;
    logic        ovf_d;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    // Highest set bit wins because the scan runs upward; 26 when bits [25:0] are all zero.
    always_comb begin
        lzc_d = 5'd26;
        for (int i = 0; i <= 25; i++) begin
            if (sum_fraction_in[i]) lzc_d = 5'(25 - i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_exp_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lzc_q   <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sum_q   <= sum_fraction_in;
                s1_exp_q   <= exponent_in;
                s1_carry_q <= sum_fraction_in[26];
                s1_zero_q  <= (sum_fraction_in == 27'd0);
                s1_lzc_q   <= lzc_d;
            end
        end
    end

    always_comb begin
        exp_inc = {1'b0, s1_exp_q} + 9'd1;
        exp_m1  = {1'b0, s1_exp_q} - 9'd1;
        shift   = '0;
        shifted = '0;
        frac_d  = '0;
        exp_d   = '0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        if (s1_zero_q) begin
            zero_d = 1'b1;
        end else if (s1_carry_q) begin
            if (exp_inc >= 9'd255) begin
                ovf_d = 1'b1;
                exp_d = 8'hff;
            end else begin
                frac_d = {s1_sum_q[26:2], s1_sum_q[1] | s1_sum_q[0]};
                exp_d  = exp_inc[7:0];
            end
        end else if (s1_sum_q[25]) begin
            frac_d = s1_sum_q[25:0];
            exp_d  = s1_exp_q;
        end else begin
            // Shift is capped so the exponent never drops below 1; exponent 0 never shifts.
            if (s1_exp_q == 8'd0) begin
                shift = '0;
            end else if ({4'b0, s1_lzc_q} <= exp_m1) begin
                shift = s1_lzc_q;
            end else begin
                shift = exp_m1[4:0];
            end
            shifted = s1_sum_q[25:1] << shift;
            frac_d  = {shifted, s1_sum_q[0]};
            exp_d   = s1_exp_q - {3'b0, shift};
            if (!shifted[24]) exp_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid               <= 1'b0;
            normalized_fraction_out <= '0;
            exponent_out            <= '0;
            zero_out                <= 1'b0;
            overflow_out            <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                normalized_fraction_out <= frac_d;
                exponent_out            <= exp_d;
                zero_out                <= zero_d;
                overflow_out            <= ovf_d;
            end
        end
    end

endmodule
